mantissa_alu_pipe: RTL and testbench



---
 rtl/mantissa_alu_pipe.sv | 128 ++++++++++++
 tb/tb_mantissa_alu_pipe.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mantissa_alu_pipe.sv
// Pipelined sign-magnitude mantissa add/subtract with zero and leading-zero flags.
// Define MANTISSA_ALU_PIPE_LZC_EN to build the leading-zero counter on o_lzc.
module mantissa_alu_pipe #(
    parameter int SIZE_MANTISSA = 28,
    parameter int NUM_STAGE     = 2,
    localparam int SIZE_LZC     = $clog2(SIZE_MANTISSA + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic                     i_op_sub,
    input  logic                     i_sign_a,
    input  logic                     i_sign_b,
    input  logic [SIZE_MANTISSA-1:0] i_mantissa_a,
    input  logic [SIZE_MANTISSA-1:0] i_mantissa_b,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_sign_result,
    output logic [SIZE_MANTISSA-1:0] o_mantissa_result,
    output logic                     o_overflow,
    output logic                     o_zero,
    output logic [SIZE_LZC-1:0]      o_lzc
);

    typedef struct packed {
        logic                     sign;
        logic                     ovf;
        logic [SIZE_MANTISSA-1:0] mant;
    } stage_t;

    logic                   eff_sub;
    logic [SIZE_MANTISSA:0] sum;
    logic [SIZE_MANTISSA:0] diff;
    logic                   borrow;
    stage_t                 stage_d;
    stage_t                 last_in;
    stage_t                 out_q;
    logic                   zero_q;
    logic [NUM_STAGE:1]     vld_q;
    logic [NUM_STAGE:0]     vld_pipe;
    logic                   advance;

    assign vld_pipe = {vld_q, i_valid};
    assign o_valid  = vld_pipe[NUM_STAGE];
    assign o_ready  = ~o_valid | i_ready;
    assign advance  = o_ready;

    assign eff_sub = i_op_sub ^ i_sign_a ^ i_sign_b;
    assign sum     = {1'b0, i_mantissa_a} + {1'b0, i_mantissa_b};
    // One wide subtractor: its borrow both orders the operands and picks the negation.
    assign diff    = {1'b0, i_mantissa_a} - {1'b0, i_mantissa_b};
    assign borrow  = diff[SIZE_MANTISSA];

    always_comb begin
        stage_d = '0;
        if (!eff_sub) begin
            stage_d.mant = sum[SIZE_MANTISSA-1:0];
            stage_d.ovf  = sum[SIZE_MANTISSA];
            stage_d.sign = i_sign_a;
        end else if (borrow) begin
            stage_d.mant = ~diff[SIZE_MANTISSA-1:0] + 1'b1;
            stage_d.sign = i_sign_b ^ i_op_sub;
        end else begin
            stage_d.mant = diff[SIZE_MANTISSA-1:0];
            stage_d.sign = (diff[SIZE_MANTISSA-1:0] != '0) ? i_sign_a : 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     vld_q <= '0;
        else if (advance) vld_q <= vld_pipe[NUM_STAGE-1:0];
    end

    generate
        if (NUM_STAGE == 1) begin : g_direct
            assign last_in = stage_d;
        end else begin : g_dly
            // Stage 1 holds the add/subtract result; later entries are pure delay.
            stage_t dly_q [1:NUM_STAGE-1];
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int k = 1; k < NUM_STAGE; k++) dly_q[k] <= '0;
                end else if (advance) begin
                    if (vld_pipe[0]) dly_q[1] <= stage_d;
                    for (int k = 2; k < NUM_STAGE; k++)
                        if (vld_pipe[k-1]) dly_q[k] <= dly_q[k-1];
                end
            end
            assign last_in = dly_q[NUM_STAGE-1];
        end
    endgenerate

`ifdef MANTISSA_ALU_PIPE_LZC_EN
    logic [SIZE_LZC-1:0] lzc_q;

    function automatic logic [SIZE_LZC-1:0] lzc_f(input logic [SIZE_MANTISSA-1:0] v);
        lzc_f = SIZE_LZC'(SIZE_MANTISSA);
        for (int i = 0; i < SIZE_MANTISSA; i++)
            if (v[i]) lzc_f = SIZE_LZC'(SIZE_MANTISSA - 1 - i);
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                            lzc_q <= '0;
        else if (advance && vld_pipe[NUM_STAGE-1]) lzc_q <= lzc_f(last_in.mant);
    end

    assign o_lzc = lzc_q;
`else
    assign o_lzc = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q  <= '0;
            zero_q <= 1'b0;
        end else if (advance && vld_pipe[NUM_STAGE-1]) begin
            out_q  <= last_in;
            zero_q <= (last_in.mant == '0);
        end
    end

    assign o_sign_result     = out_q.sign;
    assign o_mantissa_result = out_q.mant;
    assign o_overflow        = out_q.ovf;
    assign o_zero            = zero_q;

endmodule

// File: tb/tb_mantissa_alu_pipe.sv
// Directed bench for mantissa_alu_pipe (SIZE_MANTISSA=8, NUM_STAGE=2).
module tb_mantissa_alu_pipe;

    logic       i_clk = 1'b0;
    logic       i_rst_n, i_valid, o_ready, i_op_sub, i_sign_a, i_sign_b;
    logic [7:0] i_mantissa_a, i_mantissa_b, o_mantissa_result;
    logic       o_valid, i_ready, o_sign_result, o_overflow, o_zero;
    logic [3:0] o_lzc;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    mantissa_alu_pipe #(.SIZE_MANTISSA(8), .NUM_STAGE(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op_sub(i_op_sub), .i_sign_a(i_sign_a), .i_sign_b(i_sign_b),
        .i_mantissa_a(i_mantissa_a), .i_mantissa_b(i_mantissa_b),
        .o_valid(o_valid), .i_ready(i_ready), .o_sign_result(o_sign_result),
        .o_mantissa_result(o_mantissa_result), .o_overflow(o_overflow),
        .o_zero(o_zero), .o_lzc(o_lzc)
    );

    // Hand-computed vectors: a, b, sign_a, sign_b, op_sub -> result, ovf, sign, zero, lzc
    logic [7:0] t_a   [8] = '{8'h80, 8'h10, 8'h55, 8'h30, 8'h0F, 8'h01, 8'hFF, 8'h00};
    logic [7:0] t_b   [8] = '{8'h80, 8'h30, 8'h55, 8'h10, 8'h01, 8'hFF, 8'hFF, 8'h01};
    logic       t_sa  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       t_sb  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       t_sub [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] t_res [8] = '{8'h00, 8'h20, 8'h00, 8'h20, 8'h10, 8'hFE, 8'hFE, 8'h01};
    logic       t_ovf [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       t_sgn [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       t_zro [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] t_lzc [8] = '{4'd8, 4'd2, 4'd8, 4'd2, 4'd3, 4'd0, 4'd0, 4'd7};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_lzc(input logic [3:0] v);
`ifdef MANTISSA_ALU_PIPE_LZC_EN
        return v;
`else
        return 4'd0;
`endif
    endfunction

    task automatic apply(input int i, input logic v);
        i_valid      = v;
        i_op_sub     = t_sub[i];
        i_sign_a     = t_sa[i];
        i_sign_b     = t_sb[i];
        i_mantissa_a = t_a[i];
        i_mantissa_b = t_b[i];
    endtask

    task automatic chk_result(input string tag, input int i);
        chk({tag, ".res"},  64'(o_mantissa_result), 64'(t_res[i]));
        chk({tag, ".ovf"},  64'(o_overflow),        64'(t_ovf[i]));
        chk({tag, ".sign"}, 64'(o_sign_result),     64'(t_sgn[i]));
        chk({tag, ".zero"}, 64'(o_zero),            64'(t_zro[i]));
        chk({tag, ".lzc"},  64'(o_lzc),             64'(exp_lzc(t_lzc[i])));
    endtask

    initial begin
        int n_in, n_out, cyc;
        logic saw_stall;

        i_rst_n = 1'b0; i_ready = 1'b1;
        apply(0, 1'b0);
        repeat (2) @(negedge i_clk);
        chk("rst.valid", 64'(o_valid), 64'd0);
        chk("rst.ready", 64'(o_ready), 64'd1);
        chk("rst.res",   64'(o_mantissa_result), 64'd0);
        chk("rst.flags", 64'({o_sign_result, o_overflow, o_zero, o_lzc}), 64'd0);
        i_rst_n = 1'b1;

        // Single ops with no stall: exact 2-cycle latency.
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            apply(i, 1'b1);
            @(negedge i_clk);
            i_valid = 1'b0;
            chk($sformatf("op%0d.lat1", i), 64'(o_valid), 64'd0);
            @(negedge i_clk);
            chk($sformatf("op%0d.valid", i), 64'(o_valid), 64'd1);
            chk_result($sformatf("op%0d", i), i);
        end
        @(negedge i_clk);
        chk("drain.valid", 64'(o_valid), 64'd0);

        // Backpressure: four back-to-back ops, i_ready low for cycles 2..5.
        n_in = 0; n_out = 0; saw_stall = 1'b0;
        for (cyc = 0; cyc < 40 && n_out < 4; cyc++) begin
            i_ready = !(cyc >= 2 && cyc <= 5);
            if (n_in < 4) apply(n_in, 1'b1);
            else          i_valid = 1'b0;
            #1;
            if (!o_ready) saw_stall = 1'b1;
            if (o_valid) chk_result($sformatf("bp%0d", n_out), n_out);
            if (o_valid && i_ready) n_out++;
            if (i_valid && o_ready) n_in++;
            @(negedge i_clk);
        end
        i_valid = 1'b0; i_ready = 1'b1;
        chk("bp.delivered", 64'(n_out), 64'd4);
        chk("bp.stalled",   64'(saw_stall), 64'd1);
        @(negedge i_clk);
        chk("bp.no_dup", 64'(o_valid), 64'd0);

        // Reset with two ops in flight.
        apply(1, 1'b1);
        @(negedge i_clk);
        apply(2, 1'b1);
        @(negedge i_clk);
        i_valid = 1'b0; i_ready = 1'b0;
        chk("rip.pre_valid", 64'(o_valid), 64'd1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("rip.valid", 64'(o_valid), 64'd0);
        chk("rip.ready", 64'(o_ready), 64'd1);
        chk("rip.res",   64'(o_mantissa_result), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1; i_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            chk($sformatf("rip.ghost%0d", c), 64'(o_valid), 64'd0);
        end
        chk("rip.ready_after", 64'(o_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
